sa_ram_rws_param: RTL and testbench

- Parametrised 1R1W synchronous RAM model; successor to the fixed 256x256 register-file model for FPGA/simulation builds.
- Adds configurable width and depth, byte-lane write enables, and a selectable read-during-write policy.
- Adds an optional output pipeline stage, a read-valid strobe, held read data, and out-of-range protection.
- Sits under the systolic-array buffer wrappers wherever a single-clock read/write scratch RAM is instantiated.

---
 rtl/sa_ram_rws_param.sv | 120 ++++++++++++
 tb/tb_sa_ram_rws_param.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_ram_rws_param.sv
// Parametrised 1R1W synchronous scratch RAM with byte-lane writes, selectable
// read-during-write policy, optional output register and held read data.
module sa_ram_rws_param #(
  parameter int DATA_W    = 256,
  parameter int DEPTH     = 256,
  parameter int ADDR_W    = 8,
  parameter int RD_BYPASS = 1,
  parameter int OUT_REG   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   ra,
  input  logic                re,
  output logic [DATA_W-1:0]   dout,
  output logic                dout_vld,
  output logic                rd_oor,
  input  logic [ADDR_W-1:0]   wa,
  input  logic                we,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic [DATA_W-1:0]   di,
  input  logic [31:0]         pwrbus_ram_pd
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              rd_in_rng;
  logic              wr_in_rng;
  logic              collide;
  logic [DATA_W-1:0] rd_word;

  // Power-down bus is accepted for interface compatibility only.
  logic pwrbus_unused;
  assign pwrbus_unused = ^pwrbus_ram_pd;

  always_comb begin
    rd_in_rng = ({1'b0, ra} < DEPTH_L);
    wr_in_rng = ({1'b0, wa} < DEPTH_L);
    collide   = we && wr_in_rng && (ra == wa);
    rd_word   = '0;
    if (rd_in_rng) begin
      rd_word = mem[ra];
      // Write-first: lanes being written this edge are forwarded from di.
      if (RD_BYPASS != 0 && collide) begin
        for (int i = 0; i < NB; i++) begin
          if (wbe[i]) rd_word[8*i +: 8] = di[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we && wr_in_rng) begin
      for (int i = 0; i < NB; i++) begin
        if (wbe[i]) mem[wa][8*i +: 8] <= di[8*i +: 8];
      end
    end
  end

  // Read pipeline: dout_vld is a strobe with no ready; the consumer must take
  // dout in the cycle dout_vld is high. Data registers hold between reads.
  logic              s1_vld_q, s1_vld_d;
  logic              s1_oor_q, s1_oor_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;

  always_comb begin
    s1_vld_d  = re;
    s1_oor_d  = re && !rd_in_rng;
    s1_data_d = re ? rd_word : s1_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_oor_q  <= 1'b0;
      s1_data_q <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_oor_q  <= s1_oor_d;
      s1_data_q <= s1_data_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              s2_vld_q, s2_vld_d;
      logic              s2_oor_q, s2_oor_d;
      logic [DATA_W-1:0] s2_data_q, s2_data_d;

      always_comb begin
        s2_vld_d  = s1_vld_q;
        s2_oor_d  = s1_oor_q;
        s2_data_d = s1_vld_q ? s1_data_q : s2_data_q;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_vld_q  <= 1'b0;
          s2_oor_q  <= 1'b0;
          s2_data_q <= '0;
        end else begin
          s2_vld_q  <= s2_vld_d;
          s2_oor_q  <= s2_oor_d;
          s2_data_q <= s2_data_d;
        end
      end

      assign dout     = s2_data_q;
      assign dout_vld = s2_vld_q;
      assign rd_oor   = s2_oor_q;
    end else begin : g_no_out_reg
      assign dout     = s1_data_q;
      assign dout_vld = s1_vld_q;
      assign rd_oor   = s1_oor_q;
    end
  endgenerate

endmodule

// File: tb/tb_sa_ram_rws_param.sv
// Directed bench for sa_ram_rws_param: three instances share stimulus to cover
// write-first/latency-1, read-first/DEPTH=200 and write-first/latency-2 builds.
module tb_sa_ram_rws_param;

  localparam int DW = 256;
  localparam int BW = DW / 8;

  localparam logic [DW-1:0] V_A5 = {32{8'hA5}};
  localparam logic [DW-1:0] V_FF = {32{8'hFF}};
  localparam logic [DW-1:0] V_MK = {{29{8'hFF}}, 8'h00, 8'hFF, 8'h00};
  localparam logic [DW-1:0] V_11 = {32{8'h11}};
  localparam logic [DW-1:0] V_22 = {32{8'h22}};
  localparam logic [DW-1:0] V_33 = {32{8'h33}};
  localparam logic [DW-1:0] V_44 = {32{8'h44}};
  localparam logic [DW-1:0] V_5A = {32{8'h5A}};
  localparam logic [DW-1:0] V_77 = {32{8'h77}};
  localparam logic [DW-1:0] V_D1 = {32{8'h01}};
  localparam logic [DW-1:0] V_D2 = {32{8'h02}};
  localparam logic [DW-1:0] V_D3 = {32{8'h03}};
  localparam logic [BW-1:0] BE_ALL = '1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    ra = '0, wa = '0;
  logic          re = 1'b0, we = 1'b0;
  logic [BW-1:0] wbe = '0;
  logic [DW-1:0] di = '0;
  logic [31:0]   pwr = '0;

  logic [DW-1:0] dout_a, dout_b, dout_c;
  logic          vld_a, vld_b, vld_c;
  logic          oor_a, oor_b, oor_c;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sa_ram_rws_param #(.DATA_W(DW), .DEPTH(256), .ADDR_W(8), .RD_BYPASS(1), .OUT_REG(0)) u_a (
    .clk(clk), .rst(rst), .ra(ra), .re(re), .dout(dout_a), .dout_vld(vld_a), .rd_oor(oor_a),
    .wa(wa), .we(we), .wbe(wbe), .di(di), .pwrbus_ram_pd(pwr));

  sa_ram_rws_param #(.DATA_W(DW), .DEPTH(200), .ADDR_W(8), .RD_BYPASS(0), .OUT_REG(0)) u_b (
    .clk(clk), .rst(rst), .ra(ra), .re(re), .dout(dout_b), .dout_vld(vld_b), .rd_oor(oor_b),
    .wa(wa), .we(we), .wbe(wbe), .di(di), .pwrbus_ram_pd(pwr));

  sa_ram_rws_param #(.DATA_W(DW), .DEPTH(256), .ADDR_W(8), .RD_BYPASS(1), .OUT_REG(1)) u_c (
    .clk(clk), .rst(rst), .ra(ra), .re(re), .dout(dout_c), .dout_vld(vld_c), .rd_oor(oor_c),
    .wa(wa), .we(we), .wbe(wbe), .di(di), .pwrbus_ram_pd(pwr));

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    we = 1'b1; wa = a; di = d; wbe = be;
    cyc();
    we = 1'b0; wbe = '0;
  endtask

  task automatic rd(input logic [7:0] a);
    re = 1'b1; ra = a;
    cyc();
    re = 1'b0;
  endtask

  task automatic test_reset();
    cyc(); cyc();
    n_chk++;
    if (dout_a !== '0 || dout_b !== '0 || dout_c !== '0) begin
      n_fail++; $display("FAIL reset_dout a=%h c=%h want 0", dout_a, dout_c);
    end
    n_chk++;
    if ({vld_a, vld_b, vld_c, oor_a, oor_b, oor_c} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags got %b want 000000", {vld_a, vld_b, vld_c, oor_a, oor_b, oor_c});
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_basic();
    wr(8'd3, V_A5, BE_ALL);
    rd(8'd3);
    n_chk++;
    if (vld_a !== 1'b1 || dout_a !== V_A5 || oor_a !== 1'b0) begin
      n_fail++; $display("FAIL basic_lat1 vld=%b oor=%b dout=%h want vld=1 dout=%h", vld_a, oor_a, dout_a, V_A5);
    end
    n_chk++;
    if (vld_c !== 1'b0) begin
      n_fail++; $display("FAIL basic_lat2_early vld=%b want 0", vld_c);
    end
    cyc();
    n_chk++;
    if (vld_a !== 1'b0 || dout_a !== V_A5) begin
      n_fail++; $display("FAIL basic_hold vld=%b dout=%h want vld=0 dout=%h", vld_a, dout_a, V_A5);
    end
    n_chk++;
    if (vld_c !== 1'b1 || dout_c !== V_A5) begin
      n_fail++; $display("FAIL basic_lat2 vld=%b dout=%h want vld=1 dout=%h", vld_c, dout_c, V_A5);
    end
    cyc();
    n_chk++;
    if (vld_c !== 1'b0) begin
      n_fail++; $display("FAIL basic_lat2_pulse vld=%b want 0", vld_c);
    end
  endtask

  task automatic test_byte_mask();
    wr(8'd7, V_FF, BE_ALL);
    wr(8'd7, '0, BW'('h5));
    rd(8'd7);
    n_chk++;
    if (dout_a !== V_MK || vld_a !== 1'b1) begin
      n_fail++; $display("FAIL byte_mask dout=%h want %h", dout_a, V_MK);
    end
    cyc(); cyc();
  endtask

  task automatic test_collision();
    wr(8'd10, V_11, BE_ALL);
    re = 1'b1; ra = 8'd10; we = 1'b1; wa = 8'd10; di = V_22; wbe = BE_ALL;
    cyc();
    re = 1'b0; we = 1'b0; wbe = '0;
    n_chk++;
    if (dout_a !== V_22) begin
      n_fail++; $display("FAIL coll_write_first dout=%h want %h", dout_a, V_22);
    end
    n_chk++;
    if (dout_b !== V_11) begin
      n_fail++; $display("FAIL coll_read_first dout=%h want %h", dout_b, V_11);
    end
    cyc();
    n_chk++;
    if (dout_c !== V_22 || vld_c !== 1'b1) begin
      n_fail++; $display("FAIL coll_lat2 vld=%b dout=%h want %h", vld_c, dout_c, V_22);
    end
    rd(8'd10);
    n_chk++;
    if (dout_a !== V_22 || dout_b !== V_22) begin
      n_fail++; $display("FAIL coll_followup a=%h b=%h want %h", dout_a, dout_b, V_22);
    end
    cyc(); cyc();
  endtask

  task automatic test_oor();
    wr(8'd199, V_5A, BE_ALL);
    wr(8'd250, V_77, BE_ALL);
    rd(8'd250);
    n_chk++;
    if (dout_b !== '0 || oor_b !== 1'b1 || vld_b !== 1'b1) begin
      n_fail++; $display("FAIL oor_read vld=%b oor=%b dout=%h want vld=1 oor=1 dout=0", vld_b, oor_b, dout_b);
    end
    n_chk++;
    if (dout_a !== V_77 || oor_a !== 1'b0) begin
      n_fail++; $display("FAIL oor_inrange_256 oor=%b dout=%h want oor=0 dout=%h", oor_a, dout_a, V_77);
    end
    cyc();
    n_chk++;
    if (oor_b !== 1'b0 || vld_b !== 1'b0 || oor_c !== 1'b0) begin
      n_fail++; $display("FAIL oor_pulse oor_b=%b vld_b=%b oor_c=%b want 0", oor_b, vld_b, oor_c);
    end
    rd(8'd199);
    n_chk++;
    if (dout_b !== V_5A || oor_b !== 1'b0 || vld_b !== 1'b1) begin
      n_fail++; $display("FAIL oor_last_word oor=%b dout=%h want oor=0 dout=%h", oor_b, dout_b, V_5A);
    end
    cyc(); cyc();
  endtask

  task automatic test_back_to_back();
    wr(8'd1, V_D1, BE_ALL);
    wr(8'd2, V_D2, BE_ALL);
    wr(8'd3, V_D3, BE_ALL);
    re = 1'b1; ra = 8'd1;
    cyc();
    n_chk++;
    if (vld_c !== 1'b0) begin
      n_fail++; $display("FAIL b2b_early vld=%b want 0", vld_c);
    end
    ra = 8'd2;
    cyc();
    n_chk++;
    if (vld_c !== 1'b1 || dout_c !== V_D1) begin
      n_fail++; $display("FAIL b2b_first vld=%b dout=%h want %h", vld_c, dout_c, V_D1);
    end
    ra = 8'd3;
    cyc();
    re = 1'b0;
    n_chk++;
    if (vld_c !== 1'b1 || dout_c !== V_D2) begin
      n_fail++; $display("FAIL b2b_second vld=%b dout=%h want %h", vld_c, dout_c, V_D2);
    end
    cyc();
    n_chk++;
    if (vld_c !== 1'b1 || dout_c !== V_D3) begin
      n_fail++; $display("FAIL b2b_third vld=%b dout=%h want %h", vld_c, dout_c, V_D3);
    end
    cyc();
    n_chk++;
    if (vld_c !== 1'b0 || dout_c !== V_D3) begin
      n_fail++; $display("FAIL b2b_end vld=%b dout=%h want vld=0 dout=%h", vld_c, dout_c, V_D3);
    end
  endtask

  task automatic test_reset_mid();
    re = 1'b1; ra = 8'd1;
    cyc();
    re = 1'b0;
    rst = 1'b1;
    #1;
    n_chk++;
    if (vld_c !== 1'b0 || dout_c !== '0) begin
      n_fail++; $display("FAIL rst_async vld=%b dout=%h want 0", vld_c, dout_c);
    end
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_chk++;
      if (vld_c !== 1'b0 || dout_c !== '0) begin
        n_fail++; $display("FAIL rst_no_pulse cyc=%0d vld=%b dout=%h want 0", i, vld_c, dout_c);
      end
    end
    rd(8'd2);
    cyc();
    n_chk++;
    if (vld_c !== 1'b1 || dout_c !== V_D2) begin
      n_fail++; $display("FAIL rst_persist vld=%b dout=%h want %h", vld_c, dout_c, V_D2);
    end
    cyc();
  endtask

  task automatic test_hold();
    wr(8'd5, V_33, BE_ALL);
    rd(8'd5);
    n_chk++;
    if (dout_a !== V_33) begin
      n_fail++; $display("FAIL hold_read dout=%h want %h", dout_a, V_33);
    end
    wr(8'd5, V_44, BE_ALL);
    n_chk++;
    if (dout_a !== V_33 || vld_a !== 1'b0) begin
      n_fail++; $display("FAIL hold_after_write vld=%b dout=%h want %h", vld_a, dout_a, V_33);
    end
    cyc();
    n_chk++;
    if (dout_a !== V_33 || dout_c !== V_33) begin
      n_fail++; $display("FAIL hold_later a=%h c=%h want %h", dout_a, dout_c, V_33);
    end
    rd(8'd5);
    n_chk++;
    if (dout_a !== V_44 || vld_a !== 1'b1) begin
      n_fail++; $display("FAIL hold_next_read dout=%h want %h", dout_a, V_44);
    end
    cyc(); cyc();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_mask();
    test_collision();
    test_oor();
    test_back_to_back();
    test_reset_mid();
    test_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
